// File: rtl/sig_pkg.sv
// Shared types and defaults for the junction phase sequencer.
package sig_pkg;

    typedef enum logic [2:0] {INIT, PH_J, PH_P, PH_C, NIGHT} state_t;

    typedef logic [11:0] unit_t;

    localparam int UNIT_MAX = 4095;
    localparam int DEF_UCY  = 1;
    localparam int DEF_L    = 10;
    localparam int DEF_S    = 3;
    localparam int DEF_PT   = 4;

    // Phase lengths in units, derived from base green and extension lengths.
    function automatic unit_t len_j(input int l, input int s);
        return unit_t'(l + s);
    endfunction

    function automatic unit_t len_c(input int l, input int s);
        return unit_t'(l + 2 * s);
    endfunction

endpackage

// File: rtl/signal_phase_seq_if.sv
// Request inputs and phase-command outputs of the phase sequencer.
interface signal_phase_seq_if;
    logic           ped_req;
    logic           night_req;
    logic           J;
    logic           P;
    logic           C;
    logic           N;
    logic           phase_chg;
    sig_pkg::unit_t units_left;

    modport master (
        output ped_req, night_req,
        input  J, P, C, N, phase_chg, units_left
    );

    modport slave (
        input  ped_req, night_req,
        output J, P, C, N, phase_chg, units_left
    );
endinterface

// File: rtl/unit_tick.sv
// Unit prescaler: tick once every UCY+1 clocks, realigned by restart.
module unit_tick
    import sig_pkg::*;
#(
    parameter int UCY = DEF_UCY
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    unit_t count_reg;

    assign tick = (count_reg == unit_t'(UCY));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + unit_t'(1);
        end
    end

endmodule

// File: rtl/signal_phase_seq.sv
// Junction phase sequencer: J -> [P] -> C cycle on unit ticks, with night mode.
module signal_phase_seq
    import sig_pkg::*;
#(
    parameter int UCY = DEF_UCY,
    parameter int L   = DEF_L,
    parameter int S   = DEF_S,
    parameter int PT  = DEF_PT
) (
    input  logic               clk,
    input  logic               rst,
    signal_phase_seq_if.slave  bus
);

    localparam unit_t LEN_J = len_j(L, S);
    localparam unit_t LEN_P = unit_t'(PT);
    localparam unit_t LEN_C = len_c(L, S);

    generate
        if (UCY < 0 || UCY > UNIT_MAX || L < 1 || L > UNIT_MAX || S < 1 || S > UNIT_MAX
            || PT < 1 || PT > UNIT_MAX || (L + 2 * S) > UNIT_MAX) begin : g_bad_param
            $error("signal_phase_seq: parameter out of range");
        end
    endgenerate

    state_t state_reg, state_next;
    unit_t  cnt_reg, cnt_next;
    logic   ped_reg, ped_next;
    logic   entered_reg;
    logic   tick, restart, phase_end, ped_any;

    logic   j_reg, p_reg, c_reg, n_reg, chg_reg;
    unit_t  units_reg;

    unit_tick #(.UCY(UCY)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_next = state_reg;
        ped_any    = ped_reg | bus.ped_req;
        phase_end  = tick && (cnt_reg == unit_t'(1));
        case (state_reg)
            INIT:  state_next = PH_J;
            PH_J:  if (phase_end) state_next = bus.night_req ? NIGHT : (ped_any ? PH_P : PH_C);
            PH_P:  if (phase_end) state_next = PH_C;
            PH_C:  if (phase_end) state_next = bus.night_req ? NIGHT : PH_J;
            NIGHT: if (!bus.night_req) state_next = PH_J;
            default: state_next = INIT;
        endcase

        restart = (state_next != state_reg);

        cnt_next = cnt_reg;
        if (restart) begin
            case (state_next)
                PH_J:    cnt_next = LEN_J;
                PH_P:    cnt_next = LEN_P;
                PH_C:    cnt_next = LEN_C;
                default: cnt_next = '0;
            endcase
        end else if (tick && cnt_reg != '0) begin
            cnt_next = cnt_reg - unit_t'(1);
        end

        // The request that sends us into PH_P is consumed; any later press re-arms.
        ped_next = (restart && state_next == PH_P) ? 1'b0 : ped_any;
    end

    // Command outputs trail the internal state by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= INIT;
            cnt_reg     <= '0;
            ped_reg     <= 1'b0;
            entered_reg <= 1'b0;
            j_reg       <= 1'b0;
            p_reg       <= 1'b0;
            c_reg       <= 1'b0;
            n_reg       <= 1'b0;
            chg_reg     <= 1'b0;
            units_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ped_reg     <= ped_next;
            entered_reg <= restart;
            j_reg       <= (state_reg == PH_J);
            p_reg       <= (state_reg == PH_P);
            c_reg       <= (state_reg == PH_C);
            n_reg       <= (state_reg == NIGHT);
            chg_reg     <= entered_reg;
            units_reg   <= cnt_reg;
        end
    end

    assign bus.J          = j_reg;
    assign bus.P          = p_reg;
    assign bus.C          = c_reg;
    assign bus.N          = n_reg;
    assign bus.phase_chg  = chg_reg;
    assign bus.units_left = units_reg;

endmodule

// File: tb/tb_signal_phase_seq.sv
// Directed and random checks of signal_phase_seq against a clock-count reference model.
module tb_signal_phase_seq;

    localparam int UCY  = 1;
    localparam int L    = 10;
    localparam int S    = 3;
    localparam int PT   = 4;
    localparam int UNIT = UCY + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signal_phase_seq_if bus ();

    signal_phase_seq #(.UCY(UCY), .L(L), .S(S), .PT(PT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int fails = 0;

    // Reference model: phase code (0 init, 1 J, 2 P, 3 C, 4 night), clocks spent in phase.
    int m_ph = 0, m_el = 0;
    bit m_ped = 0, m_new = 0, m_rst = 1;
    int e_j, e_p, e_c, e_n, e_chg, e_units;

    // Observed-output trackers for the invariant checks.
    int prev_cmd = 0, run = 0;

    function automatic int len_of(input int ph);
        case (ph)
            1: return L + S;
            2: return PT;
            3: return L + 2 * S;
            default: return 0;
        endcase
    endfunction

    function automatic int cmd_code();
        if (bus.J) return 1;
        if (bus.P) return 2;
        if (bus.C) return 3;
        if (bus.N) return 4;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ped, input bit night);
        int nph;
        bit ent;
        e_j     = (m_ph == 1);
        e_p     = (m_ph == 2);
        e_c     = (m_ph == 3);
        e_n     = (m_ph == 4);
        e_chg   = m_new;
        e_units = (m_ph >= 1 && m_ph <= 3) ? len_of(m_ph) - m_el / UNIT : 0;
        m_rst   = r;
        if (r) begin
            {e_j, e_p, e_c, e_n, e_chg, e_units} = '0;
            m_ph = 0; m_el = 0; m_ped = 0; m_new = 0;
            return;
        end
        nph = m_ph;
        if (m_ph == 0) nph = 1;
        else if (m_ph == 4) begin
            if (!night) nph = 1;
        end else if (m_el + 1 == len_of(m_ph) * UNIT) begin
            if (m_ph == 2) nph = 3;
            else if (night) nph = 4;
            else if (m_ph == 1) nph = (m_ped || ped) ? 2 : 3;
            else nph = 1;
        end
        ent   = (nph != m_ph);
        m_ped = (ent && nph == 2) ? 1'b0 : (m_ped | ped);
        m_el  = ent ? 0 : m_el + 1;
        m_new = ent;
        m_ph  = nph;
    endtask

    task automatic cycle();
        int cmd;
        @(posedge clk);
        model_step(rst, bus.ped_req, bus.night_req);
        #1;
        check("J", bus.J, e_j);
        check("P", bus.P, e_p);
        check("C", bus.C, e_c);
        check("N", bus.N, e_n);
        check("phase_chg", bus.phase_chg, e_chg);
        check("units_left", bus.units_left, e_units);
        check("onehot", (bus.J + bus.P + bus.C + bus.N) <= 1, 1);
        cmd = cmd_code();
        check("units_bound", bus.units_left <= len_of(cmd), 1);
        if (m_rst) begin
            prev_cmd = 0; run = 0;
        end else if (cmd != prev_cmd) begin
            if (prev_cmd >= 1 && prev_cmd <= 3) check("min_len", run >= len_of(prev_cmd) * UNIT, 1);
            prev_cmd = cmd; run = 1;
        end else begin
            run++;
        end
    endtask

    task automatic wait_cmd(input string tag, input int code, input int max);
        int n = 0;
        while (cmd_code() != code && n < max) begin cycle(); n++; end
        check(tag, cmd_code(), code);
    endtask

    task automatic run_len(input string tag, input int code, input int exp);
        int n = 0;
        while (cmd_code() == code && n < 200) begin cycle(); n++; end
        check(tag, n, exp);
    endtask

    task automatic wait_boundary(input int ph);
        int n = 0;
        while (!(m_ph == ph && m_el == len_of(ph) * UNIT - 1) && n < 300) begin cycle(); n++; end
        check("reach_boundary", m_ph, ph);
    endtask

    initial begin
        bus.ped_req = 0;
        bus.night_req = 0;

        // Reset and release
        repeat (3) cycle();
        check("reset_units", bus.units_left, 0);
        rst = 0;
        cycle();
        check("first_J_c1", bus.J, 0);
        cycle();
        check("first_J_c2", bus.J, 1);
        check("first_chg", bus.phase_chg, 1);

        // No requests: J 26 clocks, C 32 clocks, J again
        run_len("J_len", 1, 26);
        check("C_after_J", bus.C, 1);
        check("C_chg", bus.phase_chg, 1);
        run_len("C_len", 3, 32);
        check("J_again", bus.J, 1);

        // Pedestrian pulse during J
        repeat (5) cycle();
        bus.ped_req = 1; cycle(); bus.ped_req = 0;
        wait_cmd("ped_P", 2, 40);
        run_len("P_len", 2, 8);
        run_len("C_after_P", 3, 32);
        run_len("J_no_ped", 1, 26);
        check("J_then_C", bus.C, 1);

        // Pedestrian request exactly on the J boundary
        wait_boundary(1);
        bus.ped_req = 1; cycle(); bus.ped_req = 0;
        cycle();
        check("boundary_ped_P", bus.P, 1);

        // Night and ped together at end of C
        wait_boundary(3);
        bus.night_req = 1; bus.ped_req = 1; cycle(); bus.ped_req = 0;
        cycle();
        check("night_N", bus.N, 1);
        check("night_JPC", {bus.J, bus.P, bus.C}, 3'b000);
        repeat (6) cycle();
        bus.night_req = 0;
        cycle(); cycle();
        check("night_exit_J", bus.J, 1);
        wait_cmd("latched_P", 2, 40);

        // Reset mid-C at units_left == 5
        begin
            int n = 0;
            while (!(bus.C && bus.units_left == 5) && n < 300) begin cycle(); n++; end
            check("reach_C5", bus.units_left, 5);
        end
        rst = 1; cycle();
        check("rst_cmds", {bus.J, bus.P, bus.C, bus.N, bus.phase_chg}, 5'b0);
        check("rst_units", bus.units_left, 0);
        rst = 0;
        cycle();
        check("rst_J_c1", bus.J, 0);
        cycle();
        check("rst_J_c2", bus.J, 1);

        // Random ped/night traffic
        for (int i = 0; i < 5000; i++) begin
            bus.ped_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) bus.night_req = ~bus.night_req;
            cycle();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
